// File: rtl/i2cs_apb_regfile.sv
// Register file and byte mailbox between the APB front end and the I2C slave engine.
// Holds configuration registers, a TX (APB->I2C) FIFO and an RX (I2C->APB) FIFO.
module i2cs_apb_regfile #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] reg_waddr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        reg_wrenable_i,
    input  logic [11:0] reg_raddr_i,
    output logic [31:0] reg_rdata_o,
    input  logic        reg_rd_byte_complete_i,
    output logic [6:0]  i2c_dev_addr_o,
    output logic        i2c_enable_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    localparam logic [11:0] ADDR_DEV_ADDR = 12'h000;
    localparam logic [11:0] ADDR_CTRL     = 12'h004;
    localparam logic [11:0] ADDR_TX_DATA  = 12'h008;
    localparam logic [11:0] ADDR_RX_DATA  = 12'h00C;
    localparam logic [11:0] ADDR_STATUS   = 12'h010;
    localparam logic [11:0] ADDR_CLEAR    = 12'h014;
    localparam logic [11:0] ADDR_IRQ_EN   = 12'h018;

    logic [6:0]    dev_addr_q, dev_addr_d;
    logic          enable_q, enable_d;
    logic [1:0]    irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic [11:0]   raddr_q;
    logic          rd_q;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [4:0]    tx_count_q, tx_count_d;
    logic          tx_ovf_q, tx_ovf_d;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [4:0]    rx_count_q, rx_count_d;
    logic          rx_ovf_q, rx_ovf_d;
    logic          rx_udf_q, rx_udf_d;

    logic          wr_dev, wr_ctrl, wr_tx, wr_clear, wr_irq_en;
    logic          flush_tx, flush_rx, clr_sticky;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop, pop_rx;
    logic [7:0]    rx_head;
    logic [31:0]   status;
    logic [23:0]   unused_wdata;

    assign unused_wdata = reg_wdata_i[31:8];

    assign wr_dev    = reg_wrenable_i & (reg_waddr_i == ADDR_DEV_ADDR);
    assign wr_ctrl   = reg_wrenable_i & (reg_waddr_i == ADDR_CTRL);
    assign wr_tx     = reg_wrenable_i & (reg_waddr_i == ADDR_TX_DATA);
    assign wr_clear  = reg_wrenable_i & (reg_waddr_i == ADDR_CLEAR);
    assign wr_irq_en = reg_wrenable_i & (reg_waddr_i == ADDR_IRQ_EN);

    assign flush_tx   = wr_clear & reg_wdata_i[0];
    assign flush_rx   = wr_clear & reg_wdata_i[1];
    assign clr_sticky = wr_clear & reg_wdata_i[2];

    assign tx_full  = (tx_count_q == DEPTH_C);
    assign tx_empty = (tx_count_q == 5'd0);
    assign rx_full  = (rx_count_q == DEPTH_C);
    assign rx_empty = (rx_count_q == 5'd0);

    // Rising edge of the read strobe against the address latched a cycle earlier,
    // so a strobe held for two cycles still pops only once.
    assign pop_rx = reg_rd_byte_complete_i & ~rd_q & (raddr_q == ADDR_RX_DATA);

    assign tx_push = wr_tx & ~tx_full & ~flush_tx;
    assign tx_pop  = ~tx_empty & tx_ready_i & ~flush_tx;
    assign rx_push = rx_valid_i & ~rx_full & ~flush_rx;
    assign rx_pop  = pop_rx & ~rx_empty & ~flush_rx;

    always_comb begin
        dev_addr_d = dev_addr_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        if (wr_dev) begin
            dev_addr_d = reg_wdata_i[6:0];
        end
        if (wr_ctrl) begin
            enable_d = reg_wdata_i[0];
        end
        if (wr_irq_en) begin
            irq_en_d = reg_wdata_i[1:0];
        end
    end

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (flush_tx) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end else begin
            if (tx_push) begin
                tx_wptr_d = tx_wptr_q + AW'(1);
            end
            if (tx_pop) begin
                tx_rptr_d = tx_rptr_q + AW'(1);
            end
            tx_count_d = tx_count_q + 5'(tx_push) - 5'(tx_pop);
        end
        // A new overflow outranks a same-cycle sticky clear.
        tx_ovf_d = (tx_ovf_q & ~clr_sticky) | (wr_tx & tx_full & ~flush_tx);
    end

    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (flush_rx) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end else begin
            if (rx_push) begin
                rx_wptr_d = rx_wptr_q + AW'(1);
            end
            if (rx_pop) begin
                rx_rptr_d = rx_rptr_q + AW'(1);
            end
            rx_count_d = rx_count_q + 5'(rx_push) - 5'(rx_pop);
        end
        rx_ovf_d = (rx_ovf_q & ~clr_sticky) | (rx_valid_i & rx_full & ~flush_rx);
        rx_udf_d = (rx_udf_q & ~clr_sticky) | (pop_rx & rx_empty);
    end

    assign irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_addr_q <= 7'h6F;
            enable_q   <= 1'b0;
            irq_en_q   <= 2'b00;
            irq_q      <= 1'b0;
            raddr_q    <= '0;
            rd_q       <= 1'b0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_count_q <= '0;
            rx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
        end else begin
            dev_addr_q <= dev_addr_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            raddr_q    <= reg_raddr_i;
            rd_q       <= reg_rd_byte_complete_i;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_count_q <= tx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_count_q <= rx_count_d;
            rx_ovf_q   <= rx_ovf_d;
            rx_udf_q   <= rx_udf_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= reg_wdata_i[7:0];
        end
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= rx_data_i;
        end
    end

    assign rx_head = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];

    assign status = {5'b0, rx_udf_q, rx_ovf_q, tx_ovf_q,
                     4'b0, rx_empty, rx_full, tx_empty, tx_full,
                     3'b0, rx_count_q, 3'b0, tx_count_q};

    always_comb begin
        reg_rdata_o = '0;
        case (reg_raddr_i)
            ADDR_DEV_ADDR: reg_rdata_o = {25'b0, dev_addr_q};
            ADDR_CTRL:     reg_rdata_o = {31'b0, enable_q};
            ADDR_RX_DATA:  reg_rdata_o = {24'b0, rx_head};
            ADDR_STATUS:   reg_rdata_o = status;
            ADDR_IRQ_EN:   reg_rdata_o = {30'b0, irq_en_q};
            default:       reg_rdata_o = '0;
        endcase
    end

    assign i2c_dev_addr_o = dev_addr_q;
    assign i2c_enable_o   = enable_q;
    assign tx_valid_o     = ~tx_empty;
    assign tx_data_o      = tx_empty ? 8'h00 : tx_mem_q[tx_rptr_q];
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_i2cs_apb_regfile.sv
// Directed bench for i2cs_apb_regfile: register access, both FIFOs, sticky flags,
// read-pop edge detection, interrupt timing and asynchronous reset.
module tb_i2cs_apb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] reg_waddr_i = '0;
    logic [31:0] reg_wdata_i = '0;
    logic        reg_wrenable_i = 1'b0;
    logic [11:0] reg_raddr_i = '0;
    logic [31:0] reg_rdata_o;
    logic        reg_rd_byte_complete_i = 1'b0;
    logic [6:0]  i2c_dev_addr_o;
    logic        i2c_enable_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        irq_o;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] rv;

    i2cs_apb_regfile #(.FIFO_DEPTH(8)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .reg_waddr_i            (reg_waddr_i),
        .reg_wdata_i            (reg_wdata_i),
        .reg_wrenable_i         (reg_wrenable_i),
        .reg_raddr_i            (reg_raddr_i),
        .reg_rdata_o            (reg_rdata_o),
        .reg_rd_byte_complete_i (reg_rd_byte_complete_i),
        .i2c_dev_addr_o         (i2c_dev_addr_o),
        .i2c_enable_o           (i2c_enable_o),
        .tx_data_o              (tx_data_o),
        .tx_valid_o             (tx_valid_o),
        .tx_ready_i             (tx_ready_i),
        .rx_data_i              (rx_data_i),
        .rx_valid_i             (rx_valid_i),
        .irq_o                  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
        reg_waddr_i    = a;
        reg_wdata_i    = d;
        reg_wrenable_i = 1'b1;
        tick();
        reg_wrenable_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [11:0] a, output logic [31:0] d);
        reg_raddr_i = a;
        #1;
        d = reg_rdata_o;
    endtask

    // APB read of RX_DATA: address held a cycle, data sampled, then a two-cycle strobe.
    task automatic rx_read(output logic [31:0] d);
        reg_raddr_i = 12'h00C;
        tick();
        d = reg_rdata_o;
        reg_rd_byte_complete_i = 1'b1;
        tick();
        tick();
        reg_rd_byte_complete_i = 1'b0;
        reg_raddr_i = 12'h000;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // reset state
        reg_rd(12'h000, rv); check_eq("rst_dev_addr_rd", rv, 32'h0000_006F);
        reg_rd(12'h010, rv); check_eq("rst_status", rv, 32'h000A_0000);
        check_eq("rst_irq", {31'b0, irq_o}, 32'd0);
        check_eq("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        check_eq("rst_tx_data", {24'b0, tx_data_o}, 32'd0);
        check_eq("rst_dev_addr_o", {25'b0, i2c_dev_addr_o}, 32'h6F);
        check_eq("rst_enable_o", {31'b0, i2c_enable_o}, 32'd0);

        // config registers, exact decode
        reg_wr(12'h000, 32'h0000_012A);
        check_eq("dev_addr_o", {25'b0, i2c_dev_addr_o}, 32'h2A);
        reg_rd(12'h000, rv); check_eq("dev_addr_rd", rv, 32'h2A);
        reg_wr(12'h004, 32'hFFFF_FFFF);
        check_eq("enable_o", {31'b0, i2c_enable_o}, 32'd1);
        reg_rd(12'h004, rv); check_eq("ctrl_rd", rv, 32'd1);
        reg_wr(12'h020, 32'h1234_5678);
        reg_rd(12'h020, rv); check_eq("unmapped_rd", rv, 32'd0);
        reg_rd(12'h001, rv); check_eq("inexact_rd", rv, 32'd0);
        reg_wr(12'h010, 32'hFFFF_FFFF);
        reg_rd(12'h010, rv); check_eq("status_ro", rv, 32'h000A_0000);

        // TX ordering
        reg_wr(12'h008, 32'hAB11);
        reg_wr(12'h008, 32'h22);
        reg_wr(12'h008, 32'h33);
        reg_rd(12'h010, rv); check_eq("tx_count3", rv, 32'h0008_0003);
        check_eq("tx_head", {24'b0, tx_data_o}, 32'h11);
        reg_rd(12'h008, rv); check_eq("tx_data_rd0", rv, 32'd0);
        tx_ready_i = 1'b1;
        #1;
        check_eq("tx_byte0", {23'b0, tx_valid_o, tx_data_o}, 32'h111);
        tick(); check_eq("tx_byte1", {23'b0, tx_valid_o, tx_data_o}, 32'h122);
        tick(); check_eq("tx_byte2", {23'b0, tx_valid_o, tx_data_o}, 32'h133);
        tick(); check_eq("tx_drained", {23'b0, tx_valid_o, tx_data_o}, 32'h000);
        tx_ready_i = 1'b0;

        // RX push and single pop per read
        rx_push(8'hA5);
        reg_rd(12'h010, rv); check_eq("rx_count1", rv, 32'h0002_0100);
        rx_push(8'h5A);
        reg_rd(12'h010, rv); check_eq("rx_count2", rv, 32'h0002_0200);
        rx_read(rv); check_eq("rx_read0", rv, 32'hA5);
        reg_rd(12'h010, rv); check_eq("rx_after_pop1", rv, 32'h0002_0100);
        rx_read(rv); check_eq("rx_read1", rv, 32'h5A);
        reg_rd(12'h010, rv); check_eq("rx_after_pop2", rv, 32'h000A_0000);

        // TX overflow and clear
        for (int i = 0; i < 8; i++) reg_wr(12'h008, 32'(i + 1));
        check_eq("tx_full_head", {24'b0, tx_data_o}, 32'h01);
        reg_wr(12'h008, 32'hFF);
        reg_rd(12'h010, rv); check_eq("tx_ovf_status", rv, 32'h0109_0008);
        reg_wr(12'h014, 32'h5);
        reg_rd(12'h010, rv); check_eq("tx_clear", rv, 32'h000A_0000);
        check_eq("tx_clear_valid", {31'b0, tx_valid_o}, 32'd0);

        // RX full with simultaneous push and pop
        for (int i = 0; i < 8; i++) rx_push(8'(8'h80 + i));
        reg_rd(12'h010, rv); check_eq("rx_full", rv, 32'h0006_0800);
        reg_raddr_i = 12'h00C;
        tick();
        reg_rd_byte_complete_i = 1'b1;
        rx_data_i  = 8'hEE;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        tick();
        reg_rd_byte_complete_i = 1'b0;
        reg_rd(12'h010, rv); check_eq("rx_full_pushpop", rv, 32'h0202_0700);
        reg_rd(12'h00C, rv); check_eq("rx_head_after", rv, 32'h81);

        // RX flush, then underflow
        reg_wr(12'h014, 32'h2);
        reg_rd(12'h010, rv); check_eq("rx_flush", rv, 32'h020A_0000);
        rx_read(rv); check_eq("rx_empty_read", rv, 32'd0);
        reg_rd(12'h010, rv); check_eq("rx_udf", rv, 32'h060A_0000);

        // sticky clear racing a new overflow: the set wins
        for (int i = 0; i < 8; i++) rx_push(8'(i));
        reg_waddr_i    = 12'h014;
        reg_wdata_i    = 32'h4;
        reg_wrenable_i = 1'b1;
        rx_data_i      = 8'h99;
        rx_valid_i     = 1'b1;
        tick();
        reg_wrenable_i = 1'b0;
        rx_valid_i     = 1'b0;
        reg_rd(12'h010, rv); check_eq("clr_vs_ovf", rv, 32'h0206_0800);
        reg_wr(12'h014, 32'h6);
        reg_rd(12'h010, rv); check_eq("clear_all", rv, 32'h000A_0000);

        // interrupt lags the count update by one cycle
        reg_wr(12'h018, 32'h1);
        reg_rd(12'h018, rv); check_eq("irq_en_rd", rv, 32'h1);
        tick();
        check_eq("irq_idle", {31'b0, irq_o}, 32'd0);
        rx_push(8'h42);
        reg_rd(12'h010, rv); check_eq("irq_cnt", rv, 32'h000A_0100 & 32'hFFF7_FFFF);
        check_eq("irq_not_yet", {31'b0, irq_o}, 32'd0);
        tick();
        check_eq("irq_rise", {31'b0, irq_o}, 32'd1);

        // asynchronous reset mid-fill
        reg_wr(12'h008, 32'h77);
        rx_data_i  = 8'h43;
        rx_valid_i = 1'b1;
        tick();
        tick();
        rx_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_irq", {31'b0, irq_o}, 32'd0);
        check_eq("mid_rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        check_eq("mid_rst_dev", {25'b0, i2c_dev_addr_o}, 32'h6F);
        reg_rd(12'h010, rv); check_eq("mid_rst_status", rv, 32'h000A_0000);
        reg_rd(12'h018, rv); check_eq("mid_rst_irq_en", rv, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        reg_rd(12'h010, rv); check_eq("post_rst_status", rv, 32'h000A_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
